// File: rtl/zeroriscy_mem_arb_pkg.sv
// Shared types for the zeroriscy instr/data memory arbiter.
// Owner tags identify which requester a transaction belongs to.
package zeroriscy_mem_arb_pkg;

    typedef enum logic {
        OWNER_INSTR,
        OWNER_DATA
    } owner_e;

    localparam logic [3:0] INSTR_BE = 4'hF;

endpackage

// File: rtl/zeroriscy_mem_arbiter_if.sv
// Bus bundle between fetch, LSU, arbiter and unified memory.
// slave is the arbiter's view; master is the surrounding system.
interface zeroriscy_mem_arbiter_if;

    logic        instr_req_i;
    logic        instr_gnt_o;
    logic        instr_rvalid_o;
    logic [31:0] instr_addr_i;
    logic [31:0] instr_rdata_o;

    logic        data_req_i;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic [31:0] data_rdata_o;
    logic        data_err_o;

    logic        mem_req_o;
    logic        mem_gnt_i;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        mem_err_i;

    modport slave (
        input  instr_req_i, instr_addr_i,
        input  data_req_i, data_we_i, data_be_i,
        input  data_addr_i, data_wdata_i,
        input  mem_gnt_i, mem_rvalid_i,
        input  mem_rdata_i, mem_err_i,
        output instr_gnt_o, instr_rvalid_o,
        output instr_rdata_o,
        output data_gnt_o, data_rvalid_o,
        output data_rdata_o, data_err_o,
        output mem_req_o, mem_we_o, mem_be_o,
        output mem_addr_o, mem_wdata_o
    );

    modport master (
        output instr_req_i, instr_addr_i,
        output data_req_i, data_we_i, data_be_i,
        output data_addr_i, data_wdata_i,
        output mem_gnt_i, mem_rvalid_i,
        output mem_rdata_i, mem_err_i,
        input  instr_gnt_o, instr_rvalid_o,
        input  instr_rdata_o,
        input  data_gnt_o, data_rvalid_o,
        input  data_rdata_o, data_err_o,
        input  mem_req_o, mem_we_o, mem_be_o,
        input  mem_addr_o, mem_wdata_o
    );

endinterface

// File: rtl/zeroriscy_mem_arb_fifo.sv
// Owner FIFO: remembers who issued each outstanding transaction
// so in-order responses can be routed back.
module zeroriscy_mem_arb_fifo
    import zeroriscy_mem_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push,
    input  owner_e        owner,
    input  logic          pop,
    output owner_e        head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    owner_e        mem_q [DEPTH];
    logic [PW-1:0] wr_q;
    logic [PW-1:0] rd_q;
    logic [CW-1:0] cnt_q;
    logic          push_ok;
    logic          pop_ok;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (cnt_q == CW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign head    = mem_q[rd_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_q] <= owner;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_ok) wr_q <= nxt(wr_q);
            if (pop_ok)  rd_q <= nxt(rd_q);
            unique case ({push_ok, pop_ok})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/zeroriscy_mem_arbiter.sv
// Shares one OBI memory port between zeroriscy fetch and LSU.
// Data has priority; a starvation counter eventually forces fetch.
module zeroriscy_mem_arbiter
    import zeroriscy_mem_arb_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned STARVE_LIMIT    = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    zeroriscy_mem_arbiter_if.slave  bus,
    output logic                    instr_err_o,
    output logic                    protocol_err_o
);

    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    owner_e        sel;
    owner_e        lock_owner_q;
    owner_e        head;
    logic          lock_q;
    logic [SW-1:0] starve_q;
    logic          instr_err_q;
    logic          proto_err_q;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          sel_req;
    logic          mem_req;
    logic          push;
    logic          pop;
    logic          stray;

    // A stalled request keeps its owner so address/data stay stable.
    always_comb begin
        sel = OWNER_DATA;
        if (lock_q) begin
            sel = lock_owner_q;
        end else if (starve_q == SW'(STARVE_LIMIT) && bus.instr_req_i) begin
            sel = OWNER_INSTR;
        end else if (bus.data_req_i) begin
            sel = OWNER_DATA;
        end else if (bus.instr_req_i) begin
            sel = OWNER_INSTR;
        end
    end

    assign sel_req = (sel == OWNER_INSTR) ? bus.instr_req_i
                                          : bus.data_req_i;
    assign mem_req = !rst_i && !fifo_full && sel_req;
    assign push    = mem_req && bus.mem_gnt_i;
    assign pop     = !rst_i && bus.mem_rvalid_i && !fifo_empty;
    assign stray   = bus.mem_rvalid_i && (fifo_count == '0);

    zeroriscy_mem_arb_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (push),
        .owner (sel),
        .pop   (pop),
        .head  (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        bus.mem_req_o      = 1'b0;
        bus.mem_we_o       = 1'b0;
        bus.mem_be_o       = '0;
        bus.mem_addr_o     = '0;
        bus.mem_wdata_o    = '0;
        bus.instr_gnt_o    = 1'b0;
        bus.data_gnt_o     = 1'b0;
        bus.instr_rvalid_o = 1'b0;
        bus.data_rvalid_o  = 1'b0;
        bus.instr_rdata_o  = '0;
        bus.data_rdata_o   = '0;
        bus.data_err_o     = 1'b0;
        if (!rst_i) begin
            bus.mem_req_o = mem_req;
            unique case (sel)
                OWNER_INSTR: begin
                    bus.mem_be_o   = INSTR_BE;
                    bus.mem_addr_o = bus.instr_addr_i;
                end
                OWNER_DATA: begin
                    bus.mem_we_o    = bus.data_we_i;
                    bus.mem_be_o    = bus.data_be_i;
                    bus.mem_addr_o  = bus.data_addr_i;
                    bus.mem_wdata_o = bus.data_wdata_i;
                end
            endcase
            bus.instr_gnt_o    = push && (sel == OWNER_INSTR);
            bus.data_gnt_o     = push && (sel == OWNER_DATA);
            bus.instr_rvalid_o = pop && (head == OWNER_INSTR);
            bus.data_rvalid_o  = pop && (head == OWNER_DATA);
            bus.data_err_o     = pop && (head == OWNER_DATA)
                                 && bus.mem_err_i;
            bus.instr_rdata_o  = bus.mem_rdata_i;
            bus.data_rdata_o   = bus.mem_rdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_q       <= 1'b0;
            lock_owner_q <= OWNER_INSTR;
            starve_q     <= '0;
            instr_err_q  <= 1'b0;
            proto_err_q  <= 1'b0;
        end else begin
            lock_q <= mem_req && !bus.mem_gnt_i;
            if (mem_req && !bus.mem_gnt_i) lock_owner_q <= sel;
            if (!bus.instr_req_i || (push && sel == OWNER_INSTR)) begin
                starve_q <= '0;
            end else if (push && starve_q != SW'(STARVE_LIMIT)) begin
                starve_q <= starve_q + 1'b1;
            end
            if (pop && head == OWNER_INSTR && bus.mem_err_i) begin
                instr_err_q <= 1'b1;
            end
            if (stray) proto_err_q <= 1'b1;
        end
    end

    assign instr_err_o    = instr_err_q && !rst_i;
    assign protocol_err_o = proto_err_q && !rst_i;

endmodule

// File: tb/tb_zeroriscy_mem_arbiter.sv
// Directed bench for zeroriscy_mem_arbiter with default parameters.
// Inputs change 2ns after the rising edge; outputs are checked 1ns later.
module tb_zeroriscy_mem_arbiter;

    logic clk;
    logic rst;
    logic instr_err;
    logic proto_err;
    int   total;
    int   bad;

    zeroriscy_mem_arbiter_if bus ();

    zeroriscy_mem_arbiter dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .bus            (bus),
        .instr_err_o    (instr_err),
        .protocol_err_o (proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs,
                        input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #2;
    endtask

    task automatic set_instr(input logic req, input logic [31:0] addr);
        bus.instr_req_i  = req;
        bus.instr_addr_i = addr;
    endtask

    task automatic set_data(input logic req, input logic we,
                            input logic [3:0] be, input logic [31:0] addr,
                            input logic [31:0] wdata);
        bus.data_req_i   = req;
        bus.data_we_i    = we;
        bus.data_be_i    = be;
        bus.data_addr_i  = addr;
        bus.data_wdata_i = wdata;
    endtask

    task automatic set_mem(input logic gnt, input logic rvalid,
                           input logic [31:0] rdata, input logic err);
        bus.mem_gnt_i    = gnt;
        bus.mem_rvalid_i = rvalid;
        bus.mem_rdata_i  = rdata;
        bus.mem_err_i    = err;
    endtask

    initial begin
        clk   = 1'b0;
        rst   = 1'b1;
        total = 0;
        bad   = 0;
        set_instr(1'b1, 32'h0000_0040);
        set_data(1'b1, 1'b1, 4'h3, 32'h0000_1234, 32'hCAFE_0000);
        set_mem(1'b1, 1'b1, 32'h5555_AAAA, 1'b1);

        // reset: everything forced quiet
        nxt(); #1;
        chk1("rst_mem_req", bus.mem_req_o, 1'b0);
        chk1("rst_igtn", bus.instr_gnt_o, 1'b0);
        chk1("rst_dgnt", bus.data_gnt_o, 1'b0);
        chk1("rst_irv", bus.instr_rvalid_o, 1'b0);
        chk1("rst_drv", bus.data_rvalid_o, 1'b0);
        chk32("rst_be", {28'd0, bus.mem_be_o}, 32'h0);
        chk32("rst_addr", bus.mem_addr_o, 32'h0);
        chk32("rst_drdata", bus.data_rdata_o, 32'h0);
        chk1("rst_ierr", instr_err, 1'b0);
        chk1("rst_perr", proto_err, 1'b0);
        nxt();
        set_instr(1'b0, 32'h0);
        set_data(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        set_mem(1'b0, 1'b0, 32'h0, 1'b0);
        nxt();
        rst = 1'b0;

        // single fetch
        nxt();
        set_instr(1'b1, 32'h0);
        set_mem(1'b1, 1'b0, 32'h0, 1'b0);
        #1;
        chk1("f_igtn", bus.instr_gnt_o, 1'b1);
        chk1("f_dgnt", bus.data_gnt_o, 1'b0);
        chk1("f_req", bus.mem_req_o, 1'b1);
        chk32("f_addr", bus.mem_addr_o, 32'h0);
        chk32("f_be", {28'd0, bus.mem_be_o}, 32'hF);
        chk1("f_we", bus.mem_we_o, 1'b0);
        nxt();
        set_instr(1'b0, 32'h0);
        set_mem(1'b0, 1'b1, 32'h0030_0293, 1'b0);
        #1;
        chk1("f_irv", bus.instr_rvalid_o, 1'b1);
        chk32("f_irdata", bus.instr_rdata_o, 32'h0030_0293);
        chk1("f_igtn_off", bus.instr_gnt_o, 1'b0);
        chk1("f_drv", bus.data_rvalid_o, 1'b0);
        chk1("f_derr", bus.data_err_o, 1'b0);
        chk1("f_req_off", bus.mem_req_o, 1'b0);
        nxt();
        set_mem(1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        chk1("f_irv_off", bus.instr_rvalid_o, 1'b0);
        chk1("f_perr", proto_err, 1'b0);

        // both requesting, gnt always 1: D D D D I D
        for (int c = 1; c <= 6; c++) begin
            nxt();
            set_instr(1'b1, 32'h0000_0100);
            set_data(1'b1, 1'b1, 4'h3, 32'h0000_2000, 32'hDEAD_BEEF);
            set_mem(1'b1, c > 1, 32'h0000_00A0 + c, 1'b0);
            #1;
            chk1($sformatf("s%0d_dgnt", c), bus.data_gnt_o, c != 5);
            chk1($sformatf("s%0d_igtn", c), bus.instr_gnt_o, c == 5);
            if (c > 1) begin
                chk1($sformatf("s%0d_drv", c), bus.data_rvalid_o, c != 6);
                chk1($sformatf("s%0d_irv", c), bus.instr_rvalid_o, c == 6);
            end
            if (c == 1) begin
                chk32("s1_addr", bus.mem_addr_o, 32'h0000_2000);
                chk32("s1_wdata", bus.mem_wdata_o, 32'hDEAD_BEEF);
                chk32("s1_be", {28'd0, bus.mem_be_o}, 32'h3);
                chk1("s1_we", bus.mem_we_o, 1'b1);
            end
            if (c == 5) begin
                chk32("s5_addr", bus.mem_addr_o, 32'h0000_0100);
                chk32("s5_wdata", bus.mem_wdata_o, 32'h0);
                chk32("s5_be", {28'd0, bus.mem_be_o}, 32'hF);
                chk1("s5_we", bus.mem_we_o, 1'b0);
            end
        end
        nxt();
        set_instr(1'b0, 32'h0);
        set_data(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        set_mem(1'b0, 1'b1, 32'h0, 1'b0);
        #1;
        chk1("s7_drv", bus.data_rvalid_o, 1'b1);
        chk1("s7_irv", bus.instr_rvalid_o, 1'b0);
        nxt();
        set_mem(1'b0, 1'b0, 32'h0, 1'b0);

        // stall with data selected, fetch raised meanwhile
        nxt();
        set_data(1'b1, 1'b0, 4'hF, 32'h0000_3000, 32'h0);
        #1;
        chk1("l1_req", bus.mem_req_o, 1'b1);
        chk32("l1_addr", bus.mem_addr_o, 32'h0000_3000);
        chk1("l1_dgnt", bus.data_gnt_o, 1'b0);
        nxt();
        set_instr(1'b1, 32'h0000_0400);
        #1;
        chk32("l2_addr", bus.mem_addr_o, 32'h0000_3000);
        chk1("l2_igtn", bus.instr_gnt_o, 1'b0);
        nxt();
        #1;
        chk32("l3_addr", bus.mem_addr_o, 32'h0000_3000);
        nxt();
        set_mem(1'b1, 1'b0, 32'h0, 1'b0);
        #1;
        chk1("l4_dgnt", bus.data_gnt_o, 1'b1);
        chk1("l4_igtn", bus.instr_gnt_o, 1'b0);
        nxt();
        set_data(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        set_mem(1'b1, 1'b1, 32'h0, 1'b0);
        #1;
        chk1("l5_igtn", bus.instr_gnt_o, 1'b1);
        chk32("l5_addr", bus.mem_addr_o, 32'h0000_0400);
        chk1("l5_drv", bus.data_rvalid_o, 1'b1);
        nxt();
        set_instr(1'b0, 32'h0);
        set_mem(1'b0, 1'b1, 32'h0, 1'b0);
        #1;
        chk1("l6_irv", bus.instr_rvalid_o, 1'b1);

        // fetch stalled first: later data request must not steal it
        nxt();
        set_instr(1'b1, 32'h0000_0500);
        set_mem(1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        chk32("k1_addr", bus.mem_addr_o, 32'h0000_0500);
        nxt();
        set_data(1'b1, 1'b1, 4'h1, 32'h0000_3004, 32'h0000_0077);
        #1;
        chk32("k2_addr", bus.mem_addr_o, 32'h0000_0500);
        chk1("k2_we", bus.mem_we_o, 1'b0);
        chk1("k2_dgnt", bus.data_gnt_o, 1'b0);
        nxt();
        set_mem(1'b1, 1'b0, 32'h0, 1'b0);
        #1;
        chk1("k3_igtn", bus.instr_gnt_o, 1'b1);
        chk1("k3_dgnt", bus.data_gnt_o, 1'b0);
        nxt();
        set_instr(1'b0, 32'h0);
        set_mem(1'b1, 1'b1, 32'h0, 1'b0);
        #1;
        chk1("k4_dgnt", bus.data_gnt_o, 1'b1);
        chk32("k4_addr", bus.mem_addr_o, 32'h0000_3004);
        chk1("k4_irv", bus.instr_rvalid_o, 1'b1);
        nxt();
        set_data(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        set_mem(1'b0, 1'b1, 32'h0, 1'b0);
        #1;
        chk1("k5_drv", bus.data_rvalid_o, 1'b1);

        // FIFO full, in-order routing I then D
        nxt();
        set_instr(1'b1, 32'h0000_0600);
        set_mem(1'b1, 1'b0, 32'h0, 1'b0);
        #1;
        chk1("q1_igtn", bus.instr_gnt_o, 1'b1);
        nxt();
        set_instr(1'b0, 32'h0);
        set_data(1'b1, 1'b0, 4'hF, 32'h0000_3008, 32'h0);
        #1;
        chk1("q2_dgnt", bus.data_gnt_o, 1'b1);
        nxt();
        set_instr(1'b1, 32'h0000_0604);
        #1;
        chk1("q3_req", bus.mem_req_o, 1'b0);
        chk1("q3_igtn", bus.instr_gnt_o, 1'b0);
        chk1("q3_dgnt", bus.data_gnt_o, 1'b0);
        nxt();
        set_mem(1'b1, 1'b1, 32'h1111_1111, 1'b0);
        #1;
        chk1("q4_req", bus.mem_req_o, 1'b0);
        chk1("q4_dgnt", bus.data_gnt_o, 1'b0);
        chk1("q4_irv", bus.instr_rvalid_o, 1'b1);
        chk1("q4_drv", bus.data_rvalid_o, 1'b0);
        nxt();
        set_mem(1'b1, 1'b1, 32'h2222_2222, 1'b1);
        #1;
        chk1("q5_dgnt", bus.data_gnt_o, 1'b1);
        chk1("q5_drv", bus.data_rvalid_o, 1'b1);
        chk1("q5_derr", bus.data_err_o, 1'b1);
        chk32("q5_drdata", bus.data_rdata_o, 32'h2222_2222);
        chk1("q5_irv", bus.instr_rvalid_o, 1'b0);
        nxt();
        set_instr(1'b0, 32'h0);
        set_data(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        set_mem(1'b0, 1'b1, 32'h0, 1'b0);
        #1;
        chk1("q6_drv", bus.data_rvalid_o, 1'b1);
        chk1("q6_derr", bus.data_err_o, 1'b0);
        chk1("q6_ierr", instr_err, 1'b0);

        // order D then I, error on each
        nxt();
        set_data(1'b1, 1'b0, 4'hF, 32'h0000_300C, 32'h0);
        set_mem(1'b1, 1'b0, 32'h0, 1'b0);
        #1;
        chk1("o1_dgnt", bus.data_gnt_o, 1'b1);
        nxt();
        set_data(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        set_instr(1'b1, 32'h0000_0700);
        #1;
        chk1("o2_igtn", bus.instr_gnt_o, 1'b1);
        nxt();
        set_instr(1'b0, 32'h0);
        set_mem(1'b0, 1'b1, 32'h3333_3333, 1'b1);
        #1;
        chk1("o3_drv", bus.data_rvalid_o, 1'b1);
        chk1("o3_derr", bus.data_err_o, 1'b1);
        nxt();
        set_mem(1'b0, 1'b1, 32'h4444_4444, 1'b1);
        #1;
        chk1("o4_irv", bus.instr_rvalid_o, 1'b1);
        chk1("o4_drv", bus.data_rvalid_o, 1'b0);
        chk1("o4_derr", bus.data_err_o, 1'b0);
        nxt();
        set_mem(1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        chk1("o5_ierr", instr_err, 1'b1);
        chk1("o5_perr", proto_err, 1'b0);

        // stray response, then reset with one outstanding
        nxt();
        set_mem(1'b0, 1'b1, 32'h0, 1'b0);
        #1;
        chk1("p1_irv", bus.instr_rvalid_o, 1'b0);
        chk1("p1_drv", bus.data_rvalid_o, 1'b0);
        nxt();
        set_mem(1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        chk1("p2_perr", proto_err, 1'b1);
        nxt();
        #1;
        chk1("p3_perr", proto_err, 1'b1);
        nxt();
        set_instr(1'b1, 32'h0000_0800);
        set_mem(1'b1, 1'b0, 32'h0, 1'b0);
        #1;
        chk1("p4_igtn", bus.instr_gnt_o, 1'b1);
        nxt();
        rst = 1'b1;
        #1;
        chk1("p5_req", bus.mem_req_o, 1'b0);
        chk1("p5_igtn", bus.instr_gnt_o, 1'b0);
        chk1("p5_perr", proto_err, 1'b0);
        chk1("p5_ierr", instr_err, 1'b0);
        nxt();
        rst = 1'b0;
        set_instr(1'b0, 32'h0);
        set_mem(1'b0, 1'b1, 32'h0, 1'b0);
        #1;
        chk1("p6_irv", bus.instr_rvalid_o, 1'b0);
        nxt();
        set_mem(1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        chk1("p7_perr", proto_err, 1'b1);
        chk1("p7_ierr", instr_err, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
